// File: rtl/ps_head_collector.sv
// ps_head_collector: gathers one header packet from the head-extractor stream
// into a wide parallel register. The header is then offered on a single
// valid/ready handshake, together with its word count and an overflow flag.
// Optional build macro PS_HEAD_COLLECTOR_PREFETCH_EN adds a staging bank. The
// next header is collected into it while the output bank waits for the consumer.
module ps_head_collector #(
  parameter int DWIDTH = 8,
  parameter int HWORDS = 4,
  parameter int CWIDTH = $clog2(HWORDS + 1)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DWIDTH-1:0]        s_dat,
  input  logic                     s_val,
  input  logic                     s_eop,
  output logic                     s_rdy,
  output logic [HWORDS*DWIDTH-1:0] hdr,
  output logic [CWIDTH-1:0]        hdr_len,
  output logic                     hdr_ovf,
  output logic                     hdr_val,
  input  logic                     hdr_rdy
);

  localparam logic [CWIDTH-1:0] CMAX = CWIDTH'(HWORDS);

  // Writes one word into the slot selected by the word counter.
  function automatic logic [HWORDS*DWIDTH-1:0] put_word(
    input logic [HWORDS*DWIDTH-1:0] bank,
    input logic [CWIDTH-1:0]        slot,
    input logic [DWIDTH-1:0]        dat
  );
    logic [HWORDS*DWIDTH-1:0] r;
    r = bank;
    for (int k = 0; k < HWORDS; k++) begin
      if (slot == CWIDTH'(k)) r[k*DWIDTH +: DWIDTH] = dat;
    end
    return r;
  endfunction

  // Output bank, shared by both builds.
  logic [HWORDS*DWIDTH-1:0] hdr_q, hdr_d;
  logic [CWIDTH-1:0]        cnt_q, cnt_d;
  logic                     ovf_q, ovf_d;
  logic                     acc;

  assign acc     = s_val & s_rdy;
  assign hdr     = hdr_q;
  assign hdr_len = cnt_q;
  assign hdr_ovf = ovf_q;

`ifdef PS_HEAD_COLLECTOR_PREFETCH_EN

  logic                     oval_q, oval_d;
  logic [HWORDS*DWIDTH-1:0] stg_q, stg_d;
  logic [CWIDTH-1:0]        scnt_q, scnt_d;
  logic                     sovf_q, sovf_d;
  logic                     sfull_q, sfull_d;
  logic                     hs;
  logic                     to_stg;

  // Input stalls only while staging holds a complete header still waiting for the output bank.
  assign s_rdy   = ~sfull_q;
  assign hdr_val = oval_q;
  assign hs      = oval_q & hdr_rdy;
  // Once staging has started a packet, that packet finishes there, even if the output bank drains meanwhile.
  assign to_stg  = oval_q | sfull_q | (scnt_q != '0);

  // Next-state for the output and staging banks.
  always_comb begin
    hdr_d   = hdr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    oval_d  = oval_q;
    stg_d   = stg_q;
    scnt_d  = scnt_q;
    sovf_d  = sovf_q;
    sfull_d = sfull_q;

    if ((hs || !oval_q) && sfull_q) begin
      hdr_d   = stg_q;
      cnt_d   = scnt_q;
      ovf_d   = sovf_q;
      oval_d  = 1'b1;
      stg_d   = '0;
      scnt_d  = '0;
      sovf_d  = 1'b0;
      sfull_d = 1'b0;
    end else begin
      if (hs) begin
        hdr_d  = '0;
        cnt_d  = '0;
        ovf_d  = 1'b0;
        oval_d = 1'b0;
      end else if (acc && !to_stg) begin
        if (cnt_q != CMAX) begin
          hdr_d = put_word(hdr_q, cnt_q, s_dat);
          cnt_d = cnt_q + CWIDTH'(1);
        end else begin
          ovf_d = 1'b1;
        end
        if (s_eop) oval_d = 1'b1;
      end

      if (acc && to_stg) begin
        if (scnt_q != CMAX) begin
          stg_d  = put_word(stg_q, scnt_q, s_dat);
          scnt_d = scnt_q + CWIDTH'(1);
        end else begin
          sovf_d = 1'b1;
        end
        if (s_eop) sfull_d = 1'b1;
      end
    end
  end

  // Register both banks and their valid flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hdr_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      oval_q  <= 1'b0;
      stg_q   <= '0;
      scnt_q  <= '0;
      sovf_q  <= 1'b0;
      sfull_q <= 1'b0;
    end else begin
      hdr_q   <= hdr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      oval_q  <= oval_d;
      stg_q   <= stg_d;
      scnt_q  <= scnt_d;
      sovf_q  <= sovf_d;
      sfull_q <= sfull_d;
    end
  end

`else

  typedef enum logic {COLLECT, HOLD} state_t;
  state_t state_q, state_d;

  assign s_rdy   = (state_q == COLLECT);
  assign hdr_val = (state_q == HOLD);

  // Next-state: fill slots while collecting, clear everything on output handshake.
  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      COLLECT: begin
        if (acc) begin
          if (cnt_q != CMAX) begin
            hdr_d = put_word(hdr_q, cnt_q, s_dat);
            cnt_d = cnt_q + CWIDTH'(1);
          end else begin
            ovf_d = 1'b1;
          end
          if (s_eop) state_d = HOLD;
        end
      end
      HOLD: begin
        if (hdr_rdy) begin
          state_d = COLLECT;
          hdr_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // State and header registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= COLLECT;
      hdr_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

`endif

endmodule

// File: doc/ps_head_collector.md
Name: ps_head_collector

Overview:
- Sits directly downstream of the PacketStream head extractor and consumes its header stream (h_dat/h_val/h_eop/h_rdy).
- Gathers the words of one header packet into a wide parallel register.
- Presents the gathered header, its word count and an overflow flag on a single valid/ready handshake, so control logic can parse the fields in one cycle.

Parameters:
- DWIDTH, 8: stream word width.
- HWORDS, 4: capacity of the header register, in words (≥1).
- CWIDTH, $clog2(HWORDS+1): width of the word-count output. Derived; not to be overridden.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset; asynchronous, active-low.
- s_dat  in  DWIDTH  header stream data (from extractor h_dat).
- s_val  in  1  header stream valid.
- s_eop  in  1  header stream end of packet.
- s_rdy  out  1  header stream ready.
- hdr  out  HWORDS*DWIDTH  collected header; word k at bits [k*DWIDTH +: DWIDTH]; word 0 is the first word received.
- hdr_len  out  CWIDTH  number of words stored in hdr, 1..HWORDS.
- hdr_ovf  out  1  header was longer than HWORDS; excess words discarded.
- hdr_val  out  1  hdr/hdr_len/hdr_ovf valid.
- hdr_rdy  in  1  consumer accepts the header.

Behaviour:
- Reset (reset_n low, asynchronous): state COLLECT; word counter 0; hdr all zeros; hdr_len 0; hdr_ovf 0; hdr_val 0; s_rdy 1 once reset is released.
- A word is accepted when s_val & s_rdy.
- States:
  - COLLECT: s_rdy=1, hdr_val=0.
    - Each accepted word is written to slot cnt while cnt<HWORDS; cnt increments, saturating at HWORDS.
    - An accepted word while cnt==HWORDS is dropped and sets the internal ovf flag.
    - On an accepted word with s_eop=1: the word is stored (or dropped) by the same rules, then the state goes to HOLD.
  - HOLD: s_rdy=0, hdr_val=1.
    - hdr_len = number of stored words; hdr_ovf = ovf flag.
    - On hdr_val & hdr_rdy: go to COLLECT, clear cnt, ovf and all hdr slots to 0.
- Latency: hdr_val rises on the clock edge that accepts the eop word, i.e. it is visible the cycle after that handshake.
- Slots not written in the current packet read 0; no stale data from a previous header.
- Single-word packet (first word carries eop): hdr_len=1.
- Exactly HWORDS words: hdr_len=HWORDS, hdr_ovf=0.
- HWORDS+n words: hdr_len=HWORDS, hdr_ovf=1, words HWORDS.. discarded.
- hdr_rdy held high in HOLD: one-cycle HOLD; throughput is one header per (words+1) cycles.
- s_val without s_eop is never timed out; the block waits indefinitely.
- hdr_rdy while hdr_val=0 is ignored.
- Reset asserted mid-packet or in HOLD: all state is abandoned immediately; the partial header is lost and the next word after reset is treated as word 0.
- hdr, hdr_len and hdr_ovf are registered; s_rdy and hdr_val are decoded directly from the state register (no combinational path from hdr_rdy to s_rdy).

Optional Feature:
- PS_HEAD_COLLECTOR_PREFETCH_EN.
- Defined: a second (staging) bank is added.
  - While the output bank is in HOLD, s_rdy stays 1 and the next header is collected into staging.
  - s_rdy drops only when staging has a complete header and the output bank is still held.
  - On an output handshake, a complete staging header moves to the output bank on that edge and hdr_val stays 1 without a gap; otherwise the output goes empty.
  - If an output handshake and the staging eop acceptance coincide, the staging header is transferred on the next edge.
  - Back-to-back headers then stream with no idle cycle on s_rdy.
- Undefined: single bank exactly as in Behaviour; no staging logic is generated.

Test Plan:
- DWIDTH=8, HWORDS=4. Send 3 words 0x11,0x22,0x33 (eop on 0x33), hdr_rdy=0 → next cycle hdr_val=1, hdr=0x00332211, hdr_len=3, hdr_ovf=0, s_rdy=0 until hdr_rdy pulses; then s_rdy=1 and hdr=0.
- Single word 0xA5 with eop → hdr=0x000000A5, hdr_len=1; then 4 words 0x01..0x04 → hdr=0x04030201, hdr_len=4, hdr_ovf=0 (no residue from 0xA5).
- 6 words 0x01..0x06 → hdr=0x04030201, hdr_len=4, hdr_ovf=1; 0x05 and 0x06 are accepted (s_rdy=1) but discarded.
- hdr_rdy tied 1, random s_val gaps, 100 random headers of 1..6 words → every header matches the model, with hdr_val high exactly one cycle per header.
- Pull reset_n low after 2 words of a 4-word header, release, then send 0x77 with eop → hdr=0x00000077, hdr_len=1.
- With PS_HEAD_COLLECTOR_PREFETCH_EN: two 2-word headers back-to-back with hdr_rdy=0 → s_rdy stays 1 through the second header, then 0; after two hdr_rdy pulses both headers are delivered in order, hdr_val continuous between them.
